word_copy_dma: RTL

Single-channel memory-to-memory copy engine acting as an initiator on the Ibex-style data bus (req/gnt/rvalid protocol). It copies a block of 32-bit words from a source address to a destination address, one word at a time, and reports completion and bus errors. It sits beside the core as a second bus master and targets code/data RAM and peripherals through the same slave ports the core uses.

---
 rtl/word_copy_dma.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/word_copy_dma.sv
// Single-channel word copy engine: a bus initiator that reads src[i] then writes dst[i],
// one outstanding access at a time, with completion pulse and sticky abort flag.
module word_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      bus_addr,
  output logic             bus_we,
  output logic [3:0]       bus_be,
  output logic [31:0]      bus_wdata,
  input  logic             bus_rvalid,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_err
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  state_e           state_q, state_d;
  logic [31:0]      src_q, dst_q, off_q, buf_q;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_nxt;
  logic             done_q, err_q;
  logic             launch, zlaunch, rd_ok, wr_ok, abort, last;
  bus_req_t         breq;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

  assign cnt_nxt = cnt_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    zlaunch = 1'b0;
    rd_ok   = 1'b0;
    wr_ok   = 1'b0;
    abort   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (len != '0) begin
          launch  = 1'b1;
          state_d = RD_REQ;
        end else begin
          zlaunch = 1'b1;
        end
      end
      RD_REQ: if (bus_gnt) state_d = RD_WAIT;
      RD_WAIT: if (bus_rvalid) begin
        if (bus_err) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          rd_ok   = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: if (bus_gnt) state_d = WR_WAIT;
      WR_WAIT: if (bus_rvalid) begin
        if (bus_err) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          wr_ok   = 1'b1;
          last    = (cnt_nxt == len_q);
          state_d = last ? IDLE : RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte offset 4*i is kept as its own register so address generation is a single adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      off_q  <= '0;
      buf_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= zlaunch | abort | (wr_ok & last);
      if (launch) begin
        src_q <= {src_addr[31:2], 2'b00};
        dst_q <= {dst_addr[31:2], 2'b00};
        len_q <= len;
        cnt_q <= '0;
        off_q <= '0;
        err_q <= 1'b0;
      end
      if (zlaunch) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (rd_ok) buf_q <= bus_rdata;
      if (wr_ok) begin
        cnt_q <= cnt_nxt;
        off_q <= off_q + 32'd4;
      end
      if (abort) err_q <= 1'b1;
    end
  end

  // Bus side is a pure decode of registered state: no gnt/rvalid feed-through.
  always_comb begin
    breq = '0;
    case (state_q)
      RD_REQ: begin
        breq.req  = 1'b1;
        breq.addr = src_q + off_q;
      end
      WR_REQ: begin
        breq.req   = 1'b1;
        breq.we    = 1'b1;
        breq.be    = 4'hF;
        breq.addr  = dst_q + off_q;
        breq.wdata = buf_q;
      end
      default: breq = '0;
    endcase
  end

  assign bus_req    = breq.req;
  assign bus_we     = breq.we;
  assign bus_be     = breq.be;
  assign bus_addr   = breq.addr;
  assign bus_wdata  = breq.wdata;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign error      = err_q;
  assign words_done = cnt_q;

endmodule
